gen_for_seq_acc: RTL and testbench
==================================

// Module: gen_for_seq_acc
// PURPOSE
//  Sequential (rolled) counterpart of the unrolled generate-for accumulator:
//  accepts one (A, B) operand pair via valid/ready and performs one
//  accumulation step per clock.
//  Computes XOUT = INIT + sum over i<COUNT of (i even ? A+B : A-B) - OFFSET,
//  taken mod 2**WIDTH, and returns it on a valid/ready output handshake.
//  Serves as the area-lean drop-in for the combinational variant on
//  streaming paths.
// PARAMETERS
//  WIDTH   8   operand/result width; all arithmetic mod 2**WIDTH
//  COUNT   4   number of accumulation steps; must be >= 1 (elaboration error otherwise)
//  INIT    1   accumulator load value, truncated to WIDTH
//  OFFSET  17  constant subtracted at the final step, truncated to WIDTH
// PORTS
//  CLK        in   1      clock, rising edge
//  RST_N      in   1      synchronous reset, active-low
//  IN_VALID   in   1      A/B valid
//  IN_READY   out  1      block can accept an operand pair
//  A          in   WIDTH  operand A, unsigned
//  B          in   WIDTH  operand B, unsigned
//  OUT_VALID  out  1      XOUT holds a fresh result
//  OUT_READY  in   1      consumer accepts the result
//  XOUT       out  WIDTH  result
//  BUSY       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (RST_N=0 at a CLK edge): state=IDLE, IN_READY=1, OUT_VALID=0,
//   XOUT=0, BUSY=0, internal count=0. Reset mid-RUN/DONE aborts the
//   operation; no result is emitted.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//  IDLE:
//   - IN_READY=1.
//   - On IN_VALID&IN_READY: register A, B; acc<=INIT; cnt<=0; go to RUN.
//  RUN:
//   - IN_READY=0. A/B inputs are ignored (registered copies are used).
//   - Each cycle: acc<=acc+(cnt[0]==0 ? A_r+B_r : A_r-B_r); cnt<=cnt+1.
//   - Final step (cnt==COUNT-1): XOUT<=acc+term-OFFSET; go to DONE.
//  DONE:
//   - OUT_VALID=1; XOUT stable.
//   - On OUT_READY: OUT_VALID<=0; go to IDLE.
//   - No same-cycle new acceptance (IN_READY=0 in DONE).
//  Latency and throughput:
//   - Accept edge at cycle 0 -> OUT_VALID high after edge COUNT.
//   - Minimum initiation interval is COUNT+2 cycles.
//  Arithmetic:
//   - All sums/differences are WIDTH-bit wrap-around; no saturation or flags.
//   - A-B wraps when B>A.
//  Output hold: XOUT holds its last value after the handshake until the
//   next final step or reset.
//  Backpressure: OUT_READY low holds DONE indefinitely; IN_VALID is ignored
//   while BUSY.
//  cnt width: $clog2(COUNT+1) bits; never exceeds COUNT-1 in RUN.
// TESTING
//  1. Reset: hold RST_N=0 two cycles
//     -> OUT_VALID=0, XOUT=0, IN_READY=1, BUSY=0.
//  2. Defaults, A=10, B=3, OUT_READY=1
//     -> XOUT=24 (0x18), OUT_VALID exactly 4 cycles after accept.
//  3. A=0, B=1 (A-B wraps)
//     -> XOUT=240 (0xF0).
//  4. A=255, B=255
//     -> XOUT=236 (0xEC); change A/B mid-RUN -> result unchanged.
//  5. OUT_READY=0 for 5 cycles in DONE, IN_VALID=1 throughout
//     -> XOUT held, no second accept; accept occurs only after the
//        handshake, once back in IDLE.
//  6. RST_N=0 at RUN cycle 2
//     -> no OUT_VALID pulse, XOUT=0; next op A=10, B=3 -> 24.

Source files
------------

// File: rtl/gen_for_seq_acc_if.sv
// Operand/result handshake bundle for the rolled accumulator.
// The slave side is the accumulator; the master side feeds operands and
// consumes results.
interface gen_for_seq_acc_if #(
  parameter int WIDTH = 8
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] XOUT;
  logic             BUSY;

  modport slave (
    input  IN_VALID, A, B, OUT_READY,
    output IN_READY, OUT_VALID, XOUT, BUSY
  );

  modport master (
    output IN_VALID, A, B, OUT_READY,
    input  IN_READY, OUT_VALID, XOUT, BUSY
  );
endinterface

// File: rtl/gen_for_seq_acc.sv
// Rolled accumulator: one operand pair in, COUNT accumulation steps (one per
// clock), alternating A+B / A-B terms, then INIT-seeded sum minus OFFSET out.
// All arithmetic wraps modulo 2**WIDTH.
module gen_for_seq_acc #(
  parameter int WIDTH  = 8,
  parameter int COUNT  = 4,
  parameter int INIT   = 1,
  parameter int OFFSET = 17
) (
  input logic               CLK,
  input logic               RST_N,
  gen_for_seq_acc_if.slave  bus
);

  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0]    LAST     = CW'(COUNT - 1);
  localparam logic [WIDTH-1:0] INIT_W   = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] OFFSET_W = WIDTH'(OFFSET);

  generate
    if (COUNT < 1) begin : g_count_check
      $error("gen_for_seq_acc: COUNT must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] xout_q, xout_d;
  logic [WIDTH-1:0] term;

  // Even steps add A+B, odd steps add A-B; both wrap at WIDTH bits.
  function automatic logic [WIDTH-1:0] step_term(
    input logic             odd,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    return odd ? (a - b) : (a + b);
  endfunction

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    xout_d  = xout_q;
    term    = step_term(cnt_q[0], a_q, b_q);
    case (state_q)
      IDLE: begin
        if (bus.IN_VALID) begin
          a_d     = bus.A;
          b_d     = bus.B;
          acc_d   = INIT_W;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + term;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Final step folds the offset straight into the result register.
          xout_d  = acc_q + term - OFFSET_W;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.IN_READY  = (state_q == IDLE);
  assign bus.OUT_VALID = (state_q == DONE);
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.XOUT      = xout_q;

  // Control and result register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      xout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xout_q  <= xout_d;
    end
  end

  // Operand and accumulator registers; only meaningful while RUN.
  always_ff @(posedge CLK) begin
    acc_q <= acc_d;
    a_q   <= a_d;
    b_q   <= b_d;
  end

endmodule

// File: tb/tb_gen_for_seq_acc.sv
// Directed bench for the rolled accumulator (default parameters).
module tb_gen_for_seq_acc;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  gen_for_seq_acc_if #(.WIDTH(8)) bus ();

  gen_for_seq_acc #(.WIDTH(8), .COUNT(4), .INIT(1), .OFFSET(17)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair for a single accept edge, then drop IN_VALID.
  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    bus.A        = a;
    bus.B        = b;
    bus.IN_VALID = 1'b1;
    tick();
    bus.IN_VALID = 1'b0;
  endtask

  // Cycles after the accept edge until OUT_VALID is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.OUT_VALID !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    bus.A         = '0;
    bus.B         = '0;
    tick();
    tick();
    checks++;
    if (bus.OUT_VALID !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.OUT_VALID); end
    checks++;
    if (bus.XOUT !== 8'd0) begin failures++; $display("FAIL reset_xout got=%0d exp=0", bus.XOUT); end
    checks++;
    if (bus.IN_READY !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.IN_READY); end
    checks++;
    if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    bus.OUT_READY = 1'b1;
    accept(8'd10, 8'd3);
    checks++;
    if (bus.IN_READY !== 1'b0 || bus.BUSY !== 1'b1) begin
      failures++; $display("FAIL basic_run_flags in_ready=%b busy=%b exp 0/1", bus.IN_READY, bus.BUSY);
    end
    wait_out(lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++;
    if (bus.XOUT !== 8'd24) begin failures++; $display("FAIL basic_xout got=%0d exp=24", bus.XOUT); end
    tick();
    checks++;
    if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1 || bus.BUSY !== 1'b0) begin
      failures++; $display("FAIL basic_return_idle out_valid=%b in_ready=%b busy=%b exp 0/1/0", bus.OUT_VALID, bus.IN_READY, bus.BUSY);
    end
    checks++;
    if (bus.XOUT !== 8'd24) begin failures++; $display("FAIL basic_xout_hold got=%0d exp=24", bus.XOUT); end
  endtask

  task automatic test_wrap();
    int lat;
    accept(8'd0, 8'd1);
    wait_out(lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL wrap_latency got=%0d exp=4", lat); end
    checks++;
    if (bus.XOUT !== 8'd240) begin failures++; $display("FAIL wrap_xout got=%0d exp=240", bus.XOUT); end
    tick();
  endtask

  task automatic test_midrun_change();
    int lat;
    accept(8'd255, 8'd255);
    // Scribble new operands and a stray valid while RUN.
    bus.A        = 8'd1;
    bus.B        = 8'd2;
    bus.IN_VALID = 1'b1;
    tick();
    tick();
    bus.IN_VALID = 1'b0;
    wait_out(lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL midrun_latency_remaining got=%0d exp=2", lat); end
    checks++;
    if (bus.XOUT !== 8'd236) begin failures++; $display("FAIL midrun_xout got=%0d exp=236", bus.XOUT); end
    tick();
  endtask

  task automatic test_back_pressure();
    int lat;
    int bad;
    bus.OUT_READY = 1'b0;
    bus.A         = 8'd10;
    bus.B         = 8'd3;
    bus.IN_VALID  = 1'b1;
    tick();
    wait_out(lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.OUT_VALID !== 1'b1 || bus.IN_READY !== 1'b0 || bus.XOUT !== 8'd24) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d exp=0 xout=%0d", bad, bus.XOUT); end
    // Release: handshake, then the still-valid input is accepted from IDLE.
    bus.OUT_READY = 1'b1;
    bus.A         = 8'd0;
    bus.B         = 8'd1;
    tick();
    checks++;
    if (bus.IN_READY !== 1'b1 || bus.OUT_VALID !== 1'b0) begin
      failures++; $display("FAIL bp_handshake in_ready=%b out_valid=%b exp 1/0", bus.IN_READY, bus.OUT_VALID);
    end
    tick();
    bus.IN_VALID = 1'b0;
    checks++;
    if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL bp_second_accept busy=%b exp=1", bus.BUSY); end
    wait_out(lat);
    checks++;
    if (bus.XOUT !== 8'd240) begin failures++; $display("FAIL bp_second_xout got=%0d exp=240", bus.XOUT); end
    tick();
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    accept(8'd255, 8'd255);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.OUT_VALID === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL abort_no_out_valid pulses=%0d exp=0", seen); end
    checks++;
    if (bus.XOUT !== 8'd0) begin failures++; $display("FAIL abort_xout got=%0d exp=0", bus.XOUT); end
    checks++;
    if (bus.IN_READY !== 1'b1 || bus.BUSY !== 1'b0) begin
      failures++; $display("FAIL abort_idle in_ready=%b busy=%b exp 1/0", bus.IN_READY, bus.BUSY);
    end
    accept(8'd10, 8'd3);
    wait_out(lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL abort_next_latency got=%0d exp=4", lat); end
    checks++;
    if (bus.XOUT !== 8'd24) begin failures++; $display("FAIL abort_next_xout got=%0d exp=24", bus.XOUT); end
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_midrun_change();
    test_back_pressure();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
